// File: rtl/result_writeback_packer.sv
// Result-tile writeback: reads 32 result-buffer rows (bank/shape order undone) and streams 256-bit write-data beats.
// Latency: start -> first rd_en 1 cycle, first out_valid 3 cycles; 1 beat/cycle sustained (unpacked).
// Backpressure: out_ready low holds the head beat stable; reads stall once FIFO + in-flight reads reach 2.
// Optional feature macro: RESULT_FP16_PACK_EN (FP16 tiles packed two rows per beat, 16 beats).

package params;
    typedef enum logic [1:0] {
        FP32 = 2'd0,
        FP16 = 2'd1,
        INT8 = 2'd2,
        INT4 = 2'd3
    } type_t;

    typedef enum logic [1:0] {
        M32N8   = 2'd0,
        M16N16  = 2'd1,
        M8N32   = 2'd2,
        RC_RSVD = 2'd3
    } rc_t;
endpackage

module result_writeback_packer (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  params::type_t    data_type,
    input  params::rc_t      rc,
    output logic             rd_en,
    output logic [4:0]       rd_addr,
    input  logic [7:0][31:0] rd_data,
    output logic [255:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t       state_q, state_d;
    params::rc_t  rc_q;
    logic         pack_q;
    logic [4:0]   rd_idx_q;
    logic [4:0]   beat_q;
    logic         inflight_q;
    logic         half_q;
    logic [127:0] lo_q;
    logic         done_q, done_d;

    // Two-entry beat FIFO; the head entry drives the output port directly.
    logic [255:0] fifo_dat_q [2];
    logic [1:0]   fifo_last_q;
    logic         wr_ptr_q, rd_ptr_q;
    logic [1:0]   cnt_q;

    logic         start_acc;
    logic         pop;
    logic         push;
    logic         push_last;
    logic [255:0] push_dat;
    logic [127:0] rd_halves;
    logic [1:0]   occ;
    logic         credit_ok;
    logic         pack_sel;

    // A start in the same cycle as done is dropped so a tile never chains without an idle cycle.
    assign start_acc = start && (state_q == IDLE) && !done_q;

    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = fifo_dat_q[rd_ptr_q];
    assign out_last  = out_valid && fifo_last_q[rd_ptr_q];
    assign pop       = out_valid && out_ready;

    // Credit counts the read already in flight; a pop this cycle frees a slot so
    // reads keep streaming at one per cycle when the sink never stalls.
    assign occ       = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    assign credit_ok = (occ < 2'd2);
    assign rd_en     = (state_q == READ) && credit_ok;

    assign busy = (state_q != IDLE);
    assign done = done_q;

`ifdef RESULT_FP16_PACK_EN
    assign pack_sel = (data_type == params::FP16);
`else
    // FP16 rides the unpacked path in this build; data_type has no effect.
    assign pack_sel = (data_type == params::FP16) && 1'b0;
`endif

    // Read index to buffer row: undo the bank interleave used for each tile shape.
    always_comb begin
        rd_addr = rd_idx_q;
        case (rc_q)
            params::M16N16: rd_addr = {rd_idx_q[0], rd_idx_q[4:1]};
            params::M8N32:  rd_addr = {rd_idx_q[1:0], rd_idx_q[4:2]};
            default:        rd_addr = rd_idx_q;
        endcase
    end

    // Low 16 bits of every element of the returning row, for packed FP16 beats.
    always_comb begin
        rd_halves = '0;
        for (int i = 0; i < 8; i++) begin
            rd_halves[16*i +: 16] = rd_data[i][15:0];
        end
    end

    // Beat assembly: unpacked beats push every returning row; packed beats push on the second row.
    always_comb begin
        push      = inflight_q && (!pack_q || half_q);
        push_dat  = pack_q ? {rd_halves, lo_q} : rd_data;
        push_last = (beat_q == (pack_q ? 5'd15 : 5'd31));
    end

    // Next-state logic: READ until the last read issues, DRAIN until the last beat leaves.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE:  if (start_acc) state_d = READ;
            READ:  if (rd_en && (rd_idx_q == 5'd31)) state_d = DRAIN;
            DRAIN: begin
                if (pop && out_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers: FSM, latched config, read index and in-flight flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rc_q       <= params::M32N8;
            pack_q     <= 1'b0;
            rd_idx_q   <= 5'd0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            inflight_q <= rd_en;
            if (start_acc) begin
                rc_q     <= rc;
                pack_q   <= pack_sel;
                rd_idx_q <= 5'd0;
            end else if (rd_en && (rd_idx_q != 5'd31)) begin
                rd_idx_q <= rd_idx_q + 5'd1;
            end
        end
    end

    // Assembly state: half-beat holding register and beat index of the next push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_q <= 1'b0;
            lo_q   <= '0;
            beat_q <= 5'd0;
        end else if (start_acc) begin
            half_q <= 1'b0;
            beat_q <= 5'd0;
        end else if (inflight_q) begin
            if (pack_q && !half_q) begin
                lo_q   <= rd_halves;
                half_q <= 1'b1;
            end else begin
                half_q <= 1'b0;
                if (beat_q != 5'd31) beat_q <= beat_q + 5'd1;
            end
        end
    end

    // Beat FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) fifo_dat_q[i] <= '0;
            fifo_last_q <= 2'b00;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
        end else begin
            if (push) begin
                fifo_dat_q[wr_ptr_q]  <= push_dat;
                fifo_last_q[wr_ptr_q] <= push_last;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_result_writeback_packer.sv
// Bench for result_writeback_packer: table of tile configurations plus reset / double-start sequences.
// A behavioural result buffer answers reads one cycle later; a monitor captures beats and done pulses.
// Outputs are sampled on the falling edge; inputs change 1 ns after the rising edge.

module tb_result_writeback_packer;

    logic             clk;
    logic             rst_n;
    logic             start;
    params::type_t    data_type;
    params::rc_t      rc;
    logic             rd_en;
    logic [4:0]       rd_addr;
    logic [7:0][31:0] rd_data;
    logic [255:0]     out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;
    logic             done;

    result_writeback_packer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .data_type (data_type),
        .rc        (rc),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        params::type_t dt;
        params::rc_t   rc;
        bit            rnd;
        int            beat;
        int            exp_row;
        int            nbeats;
        bit            pk;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [255:0] cap_dat [64];
    logic         cap_last [64];
    int           nbeat;
    int           first_vld;
    int           last_hs;
    int           done_cnt = 0;
    int           done_cyc = 0;
    int           t0;
    bit           rnd_ready = 0;

    logic         pend_en = 1'b0;
    logic [4:0]   pend_addr = 5'd0;
    bit           stall_pend = 0;
    logic [255:0] stall_dat;
    logic         stall_last;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [255:0] row_vec(input int r);
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = {16'hAAAA, 8'(r), 8'(i)};
        return v;
    endfunction

    function automatic logic [127:0] half_vec(input int r);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[16*i +: 16] = {8'(r), 8'(i)};
        return v;
    endfunction

    // Result buffer: row requested in one cycle is presented during the next.
    always @(negedge clk) begin
        pend_en   = rd_en;
        pend_addr = rd_addr;
    end
    always @(posedge clk) begin
        #1;
        rd_data = pend_en ? row_vec(int'(pend_addr)) : {8{32'hDEADBEEF}};
    end

    // Sink readiness: always ready, or a fair coin per cycle.
    always @(posedge clk) begin
        #1;
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: beat capture, stall stability, done pulses.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_pend = 0;
        end else begin
            if (stall_pend) begin
                chk("stall_data", out_data, stall_dat);
                chk("stall_vld_last", {254'd0, out_valid, out_last}, {254'd0, 1'b1, stall_last});
            end
            stall_pend = out_valid && !out_ready;
            stall_dat  = out_data;
            stall_last = out_last;
            if (out_valid && first_vld < 0) first_vld = cyc;
            if (out_valid && out_ready) begin
                if (nbeat < 64) begin
                    cap_dat[nbeat]  = out_data;
                    cap_last[nbeat] = out_last;
                end
                nbeat++;
                last_hs = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_at_done", {255'd0, busy}, 256'd0);
            end
        end
    end

    task automatic run_and_check(input string nm, input vec_t v, input int extra_off,
                                 output logic busy_after);
        int base;
        int seen_n;
        bit seen;
        int nlast;
        int last_idx;
        int errs;
        logic [255:0] exp;
        nbeat     = 0;
        first_vld = -1;
        last_hs   = -1;
        rnd_ready = v.rnd;
        base      = done_cnt;
        seen      = 0;
        seen_n    = 0;
        busy_after = 1'b0;
        @(posedge clk);
        #1;
        data_type = v.dt;
        rc        = v.rc;
        start     = 1'b1;
        t0        = cyc;
        for (int n = 1; n <= 700; n++) begin
            @(posedge clk);
            #1;
            start     = (n == extra_off);
            data_type = params::INT4;
            rc        = params::M8N32;
            @(negedge clk);
            if (n == 1) begin
                chk({nm, ".busy_t1"}, {255'd0, busy}, 256'd1);
                chk({nm, ".rd_en_t1"}, {255'd0, rd_en}, 256'd1);
                chk({nm, ".rd_addr_t1"}, {251'd0, rd_addr}, 256'd0);
            end
            if (n == extra_off + 1) busy_after = busy;
            if (!seen && done_cnt != base) begin
                seen   = 1;
                seen_n = n;
            end
            if (seen && n >= seen_n + 3 && n >= extra_off + 2) break;
        end
        rnd_ready = 0;

        chk({nm, ".nbeats"}, 256'(nbeat), 256'(v.nbeats));
        chk({nm, ".done_cnt"}, 256'(done_cnt - base), 256'd1);
        if (nbeat == v.nbeats) begin
            exp = v.pk ? {half_vec(v.exp_row + 1), half_vec(v.exp_row)} : row_vec(v.exp_row);
            chk({nm, ".beat"}, cap_dat[v.beat], exp);
            nlast    = 0;
            last_idx = -1;
            for (int b = 0; b < v.nbeats; b++) begin
                if (cap_last[b]) begin
                    nlast++;
                    if (last_idx < 0) last_idx = b;
                end
            end
            chk({nm, ".n_last"}, 256'(nlast), 256'd1);
            chk({nm, ".last_idx"}, 256'(last_idx), 256'(v.nbeats - 1));
            if (v.rc == params::M32N8 && !v.pk) begin
                errs = 0;
                for (int b = 0; b < v.nbeats; b++) if (cap_dat[b] !== row_vec(b)) errs++;
                chk({nm, ".order_errs"}, 256'(errs), 256'd0);
            end
        end
        if (!v.rnd && !v.pk) begin
            chk({nm, ".first_vld_lat"}, 256'(first_vld - t0), 256'd3);
            chk({nm, ".last_beat_lat"}, 256'(last_hs - t0), 256'd34);
            chk({nm, ".done_lat"}, 256'(done_cyc - t0), 256'd35);
        end
    endtask

    vec_t vt [10];
    logic ba;
    int   base_rst;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{params::FP32, params::M32N8,   1'b0, 0,  0,  32, 1'b0};
        vt[1] = '{params::FP32, params::M32N8,   1'b0, 31, 31, 32, 1'b0};
        vt[2] = '{params::INT8, params::M16N16,  1'b0, 3,  17, 32, 1'b0};
        vt[3] = '{params::INT4, params::M16N16,  1'b0, 30, 15, 32, 1'b0};
        vt[4] = '{params::FP32, params::M8N32,   1'b0, 5,  9,  32, 1'b0};
        vt[5] = '{params::INT8, params::M8N32,   1'b0, 6,  17, 32, 1'b0};
        vt[6] = '{params::FP32, params::RC_RSVD, 1'b0, 13, 13, 32, 1'b0};
`ifdef RESULT_FP16_PACK_EN
        vt[7] = '{params::FP16, params::M32N8,   1'b0, 10, 20, 16, 1'b1};
`else
        vt[7] = '{params::FP16, params::M32N8,   1'b0, 20, 20, 32, 1'b0};
`endif
        vt[8] = '{params::FP32, params::M32N8,   1'b1, 17, 17, 32, 1'b0};
        vt[9] = '{params::INT8, params::M16N16,  1'b1, 16, 8,  32, 1'b0};

        rst_n     = 1'b0;
        start     = 1'b0;
        data_type = params::FP32;
        rc        = params::M32N8;
        out_ready = 1'b1;
        rd_data   = '0;
        #23;
        chk("rst.rd_en", {255'd0, rd_en}, 256'd0);
        chk("rst.rd_addr", {251'd0, rd_addr}, 256'd0);
        chk("rst.out_data", out_data, 256'd0);
        chk("rst.out_valid", {255'd0, out_valid}, 256'd0);
        chk("rst.out_last", {255'd0, out_last}, 256'd0);
        chk("rst.busy", {255'd0, busy}, 256'd0);
        chk("rst.done", {255'd0, done}, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 10; k++) begin
            run_and_check($sformatf("vec%0d", k), vt[k], -1, ba);
        end

        // Reset in the middle of a tile: everything clears, the partial tile never completes.
        nbeat     = 0;
        first_vld = -1;
        rnd_ready = 0;
        base_rst  = done_cnt;
        @(posedge clk);
        #1;
        data_type = params::FP32;
        rc        = params::M32N8;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 0; n < 100 && nbeat < 10; n++) @(posedge clk);
        chk("midrst.reached_beat10", 256'(nbeat >= 10), 256'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst.rd_en", {255'd0, rd_en}, 256'd0);
        chk("midrst.out_data", out_data, 256'd0);
        chk("midrst.out_valid", {255'd0, out_valid}, 256'd0);
        chk("midrst.out_last", {255'd0, out_last}, 256'd0);
        chk("midrst.busy", {255'd0, busy}, 256'd0);
        chk("midrst.rd_addr", {251'd0, rd_addr}, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        chk("midrst.no_done", 256'(done_cnt - base_rst), 256'd0);
        run_and_check("after_rst", vt[0], -1, ba);

        // Second start mid-tile is ignored: one done, original shape kept.
        run_and_check("restart_busy", vt[1], 10, ba);
        chk("restart_busy.busy_after", {255'd0, ba}, 256'd1);

        // Start coincident with done is ignored; controller stays idle afterwards.
        run_and_check("start_at_done", vt[2], 35, ba);
        chk("start_at_done.busy_after", {255'd0, ba}, 256'd0);

        // A fresh start after that still yields a full tile.
        run_and_check("post_done", vt[4], -1, ba);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
